fetch_pc_ctrl: RTL and testbench
================================

// Module: fetch_pc_ctrl
// PURPOSE
//   Owns the F-stage PC of the 5-stage MIPS pipeline. Sits downstream of the D-stage
//   comparator: it consumes the comparator's 1-bit branch verdict plus D-stage jump info,
//   computes the next PC, and latches redirects that occur while instruction fetch waits.
//   Also tags the fetched instruction with delay-slot and fetch-address-error flags for CP0.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC value after reset
//   EXC_PC    32'h0000_4180  exception handler entry
//   IM_LO     32'h0000_3000  lowest legal fetch address
//   IM_HI     32'h0000_6ffc  highest legal fetch address
// PORTS
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous, active-high reset
//   d_stall        in   1   hazard stall: freeze F and D (PC holds)
//   f_wait         in   1   imem not ready: F holds, D receives a bubble
//   d_valid        in   1   D holds a real instruction (not a bubble)
//   d_is_branch    in   1   D instruction is a conditional branch
//   d_is_j         in   1   D is j/jal
//   d_is_jr        in   1   D is jr/jalr
//   cmp_taken      in   1   comparator verdict bit 0 for the D branch
//   d_pc           in   32  PC of D instruction
//   d_imm16        in   16  branch offset field
//   d_idx26        in   26  jump index field
//   d_rs_val       in   32  forwarded rs value (jr target)
//   exc_req        in   1   CP0 exception/interrupt accepted this cycle
//   eret_req       in   1   eret committing this cycle
//   epc            in   32  return address for eret
//   f_pc           out  32  current fetch address
//   f_bd           out  1   instruction at f_pc is a branch delay slot
//   f_adel         out  1   f_pc misaligned or outside [IM_LO, IM_HI]
//   redir_pending  out  1   a redirect is latched awaiting fetch
// BEHAVIOUR
//   Reset (async): f_pc=RESET_PC, f_bd=0, state=RUN, pending target=0; f_adel follows f_pc.
//   Target calc (combinational, 32-bit wrap):
//     branch: d_pc + 4 + {{14{d_imm16[15]}}, d_imm16, 2'b00}
//     j:      {(d_pc+4)[31:28], d_idx26, 2'b00};  jr: d_rs_val
//     redir = d_valid & ((d_is_branch & cmp_taken) | d_is_j | d_is_jr).
//   States: RUN (no pending redirect), PEND (target latched in pend_pc).
//   Next-PC priority each edge (highest first):
//     1 exc_req  -> f_pc=EXC_PC, state=RUN, f_bd=0 (overrides stall/wait/pending)
//     2 eret_req -> f_pc=epc,    state=RUN, f_bd=0
//     3 d_stall  -> everything holds (f_pc, f_bd, state, pend_pc)
//     4 f_wait   -> f_pc holds; if RUN & redir: pend_pc=target, state=PEND
//     5 state PEND -> f_pc=pend_pc, state=RUN
//     6 redir    -> f_pc=target
//     7 else     -> f_pc=f_pc+4 (wraps at 2^32)
//   Branch delay slot: the instruction at f_pc while the branch is in D is the slot; it
//     is always executed, with no flush. f_bd is set on the edge D advances (neither
//     d_stall nor f_wait) with a valid branch/j/jr in D, and cleared on the next advance.
//   Only one redirect can be pending: D holds a bubble after an f_wait cycle, so redir
//     cannot assert again in PEND. In PEND with redir=1, hold pend_pc and flag it in an
//     assertion.
//   f_adel = (f_pc[1:0]!=0) | (f_pc<IM_LO) | (f_pc>IM_HI), unsigned, combinational.
//     Fetch continues; CP0 raises exc_req.
//   redir_pending = (state==PEND). Latency from cmp_taken to f_pc update: 1 cycle.
// STRUCTURE
//   Shared package/header: RESET_PC, EXC_PC, IM_LO, IM_HI constants; state encodings
//     RUN=1'b0, PEND=1'b1.
//   One sub-module: npc_target_calc (combinational target + redir), instantiated once.
// TESTING
//   reset mid-run at f_pc=0x3010 -> f_pc=0x3000, f_bd=0, redir_pending=0 immediately.
//   beq at d_pc=0x3004, imm16=0xFFFF, cmp_taken=1 -> next f_pc=0x3004, f_bd=1 on slot.
//   redir with f_wait=1 for 3 cycles (target 0x3100) -> f_pc held, redir_pending=1, then
//     f_pc=0x3100 one cycle after f_wait drops.
//   exc_req while PEND and d_stall=1 -> f_pc=0x4180, redir_pending=0.
//   jr with d_rs_val=0x3002 -> f_pc=0x3002, f_adel=1; eret epc=0x3008 -> f_pc=0x3008, f_adel=0.
//   j at d_pc=0xF000_0000, idx26=0x0000C00 -> f_pc=0xF000_3000, f_adel=1.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared constants and state encoding for the F-stage PC controller.
// Imported by fetch_pc_ctrl and npc_target_calc.
package fetch_pc_ctrl_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_HI    = 32'h0000_6ffc;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_npc.sv
// Combinational redirect target and redirect-request decode for the D-stage
// control-flow instruction.
module npc_target_calc
    import fetch_pc_ctrl_pkg::*;
(
    input  logic        i_d_valid,
    input  logic        i_d_is_branch,
    input  logic        i_d_is_j,
    input  logic        i_d_is_jr,
    input  logic        i_cmp_taken,
    input  logic [31:0] i_d_pc,
    input  logic [15:0] i_d_imm16,
    input  logic [25:0] i_d_idx26,
    input  logic [31:0] i_d_rs_val,
    output logic [31:0] o_target,
    output logic        o_redir,
    output logic        o_is_cti
);

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = i_d_pc + 32'd4;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        o_target = w_pc_plus4 + branch_offset(i_d_imm16);
        if (i_d_is_jr) begin
            o_target = i_d_rs_val;
        end else if (i_d_is_j) begin
            o_target = {w_pc_plus4[31:28], i_d_idx26, 2'b00};
        end
    end

    assign o_is_cti = i_d_valid & (i_d_is_branch | i_d_is_j | i_d_is_jr);
    assign o_redir  = i_d_valid & ((i_d_is_branch & i_cmp_taken) | i_d_is_j | i_d_is_jr);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC owner: next-PC selection, redirect latching across imem waits,
// delay-slot tagging and fetch address error flag.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
    parameter logic [31:0] IM_LO    = DEF_IM_LO,
    parameter logic [31:0] IM_HI    = DEF_IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_stall,
    input  logic        f_wait,
    input  logic        d_valid,
    input  logic        d_is_branch,
    input  logic        d_is_j,
    input  logic        d_is_jr,
    input  logic        cmp_taken,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_idx26,
    input  logic [31:0] d_rs_val,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] f_pc,
    output logic        f_bd,
    output logic        f_adel,
    output logic        redir_pending
);

    state_e      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pend_pc, w_pend_pc_nxt;
    logic        r_bd, w_bd_nxt;
    logic [31:0] w_target;
    logic        w_redir;
    logic        w_is_cti;

    npc_target_calc u_npc (
        .i_d_valid     (d_valid),
        .i_d_is_branch (d_is_branch),
        .i_d_is_j      (d_is_j),
        .i_d_is_jr     (d_is_jr),
        .i_cmp_taken   (cmp_taken),
        .i_d_pc        (d_pc),
        .i_d_imm16     (d_imm16),
        .i_d_idx26     (d_idx26),
        .i_d_rs_val    (d_rs_val),
        .o_target      (w_target),
        .o_redir       (w_redir),
        .o_is_cti      (w_is_cti)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC;
            r_pend_pc <= 32'd0;
            r_bd      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_bd      <= w_bd_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_pc_nxt = r_pend_pc;
        w_bd_nxt      = r_bd;
        if (exc_req) begin
            w_pc_nxt    = EXC_PC;
            w_state_nxt = ST_RUN;
            w_bd_nxt    = 1'b0;
        end else if (eret_req) begin
            w_pc_nxt    = epc;
            w_state_nxt = ST_RUN;
            w_bd_nxt    = 1'b0;
        end else if (d_stall) begin
            w_state_nxt = r_state;
        end else if (f_wait) begin
            // Redirect resolved while imem stalls is parked until fetch resumes.
            if (r_state == ST_RUN && w_redir) begin
                w_pend_pc_nxt = w_target;
                w_state_nxt   = ST_PEND;
            end
        end else begin
            w_bd_nxt = w_is_cti;
            if (r_state == ST_PEND) begin
                w_pc_nxt    = r_pend_pc;
                w_state_nxt = ST_RUN;
            end else if (w_redir) begin
                w_pc_nxt = w_target;
            end else begin
                w_pc_nxt = r_pc + 32'd4;
            end
        end
    end

    // D always carries a bubble after an imem wait, so a second redirect cannot arrive in PEND.
    a_single_pending: assert property (@(posedge clk) disable iff (reset)
        !(r_state == ST_PEND && w_redir));

    assign f_pc          = r_pc;
    assign f_bd          = r_bd;
    assign f_adel        = (r_pc[1:0] != 2'b00) | (r_pc < IM_LO) | (r_pc > IM_HI);
    assign redir_pending = (r_state == ST_PEND);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed-vector bench for fetch_pc_ctrl: stimulus pushes hand-computed
// expectations into a queue, a monitor pops and compares after each edge.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_stall, f_wait, d_valid, d_is_branch, d_is_j, d_is_jr, cmp_taken;
    logic [31:0] d_pc;
    logic [15:0] d_imm16;
    logic [25:0] d_idx26;
    logic [31:0] d_rs_val;
    logic        exc_req, eret_req;
    logic [31:0] epc;
    logic [31:0] f_pc;
    logic        f_bd, f_adel, redir_pending;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        bd;
        logic        adel;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .d_stall       (d_stall),
        .f_wait        (f_wait),
        .d_valid       (d_valid),
        .d_is_branch   (d_is_branch),
        .d_is_j        (d_is_j),
        .d_is_jr       (d_is_jr),
        .cmp_taken     (cmp_taken),
        .d_pc          (d_pc),
        .d_imm16       (d_imm16),
        .d_idx26       (d_idx26),
        .d_rs_val      (d_rs_val),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .f_pc          (f_pc),
        .f_bd          (f_bd),
        .f_adel        (f_adel),
        .redir_pending (redir_pending)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic check_all(input exp_t e);
        check({e.name, ".f_pc"}, f_pc, e.pc);
        check({e.name, ".f_bd"}, {31'd0, f_bd}, {31'd0, e.bd});
        check({e.name, ".f_adel"}, {31'd0, f_adel}, {31'd0, e.adel});
        check({e.name, ".redir_pending"}, {31'd0, redir_pending}, {31'd0, e.pend});
    endtask

    task automatic idle();
        d_stall = 0; f_wait = 0; d_valid = 0; d_is_branch = 0; d_is_j = 0; d_is_jr = 0;
        cmp_taken = 0; d_pc = '0; d_imm16 = '0; d_idx26 = '0; d_rs_val = '0;
        exc_req = 0; eret_req = 0; epc = '0;
    endtask

    // Inputs are already set; queue the state expected after the coming edge.
    task automatic cyc(input string name, input logic [31:0] pc, input logic bd,
                       input logic adel, input logic pend);
        exp_t e;
        e.name = name; e.pc = pc; e.bd = bd; e.adel = adel; e.pend = pend;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare after every rising edge for which an expectation exists.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all(e);
            end
        end
    end

    initial begin
        exp_t r;
        idle();
        reset = 1'b1;
        #2;
        r.name = "reset"; r.pc = 32'h3000; r.bd = 0; r.adel = 0; r.pend = 0;
        check_all(r);
        @(negedge clk);
        reset = 1'b0;

        cyc("seq1", 32'h3004, 0, 0, 0);
        cyc("seq2", 32'h3008, 0, 0, 0);
        cyc("seq3", 32'h300C, 0, 0, 0);
        d_valid = 1; d_is_branch = 1; cmp_taken = 0;
        cyc("bnt_pre", 32'h3010, 1, 0, 0);
        idle();

        // Asynchronous reset mid-run with f_bd set.
        #2;
        reset = 1'b1;
        #1;
        r.name = "reset_mid"; r.pc = 32'h3000; r.bd = 0; r.adel = 0; r.pend = 0;
        check_all(r);
        @(negedge clk);
        reset = 1'b0;

        cyc("run1", 32'h3004, 0, 0, 0);
        cyc("run2", 32'h3008, 0, 0, 0);

        // beq backwards to itself: 0x3004 + 4 - 4.
        d_valid = 1; d_is_branch = 1; cmp_taken = 1; d_pc = 32'h3004; d_imm16 = 16'hFFFF;
        cyc("beq_taken", 32'h3004, 1, 0, 0);
        idle();
        cyc("after_beq", 32'h3008, 0, 0, 0);
        d_valid = 1; d_is_branch = 1; cmp_taken = 0; d_pc = 32'h3004; d_imm16 = 16'hFFFF;
        cyc("beq_not_taken", 32'h300C, 1, 0, 0);
        idle();
        cyc("after_bnt", 32'h3010, 0, 0, 0);

        // j to 0x3100 while imem waits for 3 cycles.
        d_valid = 1; d_is_j = 1; d_pc = 32'h3000; d_idx26 = 26'h0000C40; f_wait = 1;
        cyc("wait1", 32'h3010, 0, 0, 1);
        idle(); f_wait = 1;
        cyc("wait2", 32'h3010, 0, 0, 1);
        cyc("wait3", 32'h3010, 0, 0, 1);
        idle();
        cyc("pend_release", 32'h3100, 0, 0, 0);
        cyc("after_release", 32'h3104, 0, 0, 0);

        // Exception overrides a pending redirect under stall.
        d_valid = 1; d_is_jr = 1; d_rs_val = 32'h3200; f_wait = 1;
        cyc("jr_wait", 32'h3104, 0, 0, 1);
        idle(); d_stall = 1;
        cyc("stall_pend", 32'h3104, 0, 0, 1);
        exc_req = 1;
        cyc("exc_over_pend", 32'h4180, 0, 0, 0);
        idle();
        cyc("after_exc", 32'h4184, 0, 0, 0);

        d_valid = 1; d_is_jr = 1; d_rs_val = 32'h3002;
        cyc("jr_misaligned", 32'h3002, 1, 1, 0);
        idle(); eret_req = 1; epc = 32'h3008;
        cyc("eret", 32'h3008, 0, 0, 0);
        idle();

        d_valid = 1; d_is_j = 1; d_pc = 32'hF000_0000; d_idx26 = 26'h0000C00;
        cyc("j_high", 32'hF000_3000, 1, 1, 0);
        idle();
        cyc("after_j_high", 32'hF000_3004, 0, 1, 0);

        // PC wrap at 2^32 and range edges.
        d_valid = 1; d_is_jr = 1; d_rs_val = 32'hFFFF_FFFC;
        cyc("jr_top", 32'hFFFF_FFFC, 1, 1, 0);
        idle();
        cyc("wrap_zero", 32'h0000_0000, 0, 1, 0);
        d_valid = 1; d_is_jr = 1; d_rs_val = 32'h6FFC;
        cyc("im_hi_legal", 32'h6FFC, 1, 0, 0);
        idle();
        cyc("past_im_hi", 32'h7000, 0, 1, 0);

        exc_req = 1; eret_req = 1; epc = 32'h3008;
        cyc("exc_over_eret", 32'h4180, 0, 0, 0);
        idle();

        // Forward branch: 0x3000 + 4 + 0x40; then a stall holds PC and f_bd.
        d_valid = 1; d_is_branch = 1; cmp_taken = 1; d_pc = 32'h3000; d_imm16 = 16'h0010;
        cyc("beq_fwd", 32'h3044, 1, 0, 0);
        d_stall = 1;
        cyc("stall_hold", 32'h3044, 1, 0, 0);
        idle();
        cyc("after_stall", 32'h3048, 0, 0, 0);
        f_wait = 1; eret_req = 1; epc = 32'h3010;
        cyc("eret_over_wait", 32'h3010, 0, 0, 0);
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
